cnt6_seq_ctrl: RTL

- Run controller for the six-state code counter (state codes 010→011→111→110→100→000→010).
- Owns the counter state and sequences it through a programmed number of full laps.
- Supports start, pause and stop commands and drives the carry output.
- Signals completion with a one-cycle done pulse. Sits between the control FSM and anything consuming Q/C.

---
 rtl/cnt6_seq_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cnt6_seq_ctrl.sv
// cnt6_seq_ctrl: runs the six-code counter (010,011,111,110,100,000) for a programmed lap count.
// Optional macro CNT6_DIR_EN adds a dir input that selects reverse-order runs.
module cnt6_seq_ctrl #(
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic [LAP_W-1:0] laps,
`ifdef CNT6_DIR_EN
  input  logic             dir,
`endif
  output logic             busy,
  output logic [2:0]       Q,
  output logic             C,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_e;

  localparam logic [2:0] CODE_HOME = 3'b010;
  localparam logic [2:0] CODE_LAST = 3'b000;

  state_e           state_q, state_d;
  logic [2:0]       q_q, q_d;
  logic             c_q, c_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic             rev_q, rev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dir_in;
  logic             boundary;
  logic [LAP_W-1:0] lap_inc;

`ifdef CNT6_DIR_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  // Illegal codes (001, 101) recover to the home code in either direction.
  function automatic logic [2:0] step_code(input logic [2:0] cur, input logic rev);
    logic [2:0] nxt;
    nxt = CODE_HOME;
    if (!rev) begin
      case (cur)
        3'b010:  nxt = 3'b011;
        3'b011:  nxt = 3'b111;
        3'b111:  nxt = 3'b110;
        3'b110:  nxt = 3'b100;
        3'b100:  nxt = 3'b000;
        default: nxt = CODE_HOME;
      endcase
    end else begin
      case (cur)
        3'b000:  nxt = 3'b100;
        3'b100:  nxt = 3'b110;
        3'b110:  nxt = 3'b111;
        3'b111:  nxt = 3'b011;
        3'b011:  nxt = 3'b010;
        3'b010:  nxt = 3'b000;
        default: nxt = CODE_HOME;
      endcase
    end
    return nxt;
  endfunction

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    lap_cnt_d = lap_cnt_q;
    laps_d    = laps_q;
    rev_d     = rev_q;
    lap_inc   = lap_cnt_q + LAP_W'(1);
    boundary  = rev_q ? (q_q == CODE_HOME) : (q_q == CODE_LAST);
    case (state_q)
      S_IDLE: begin
        q_d = CODE_HOME;
        if (start && !stop) begin
          state_d   = S_RUN;
          laps_d    = laps;
          lap_cnt_d = '0;
          rev_d     = dir_in;
          q_d       = dir_in ? CODE_LAST : CODE_HOME;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          q_d     = CODE_HOME;
        end else if (pause) begin
          state_d = S_HOLD;
        end else begin
          q_d = step_code(q_q, rev_q);
          if (boundary) begin
            lap_cnt_d = lap_inc;
            // laps_q == 0 is free-run: only stop or reset end it.
            if (laps_q != '0 && lap_inc == laps_q) begin
              state_d = S_DONE;
              q_d     = CODE_HOME;
            end
          end
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
          q_d     = CODE_HOME;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        q_d     = CODE_HOME;
      end
    endcase
    // Carry marks the last code of a lap, which depends on the run direction.
    c_d    = (state_d == S_RUN) && (q_d == (rev_d ? CODE_HOME : CODE_LAST));
    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      q_q       <= CODE_HOME;
      c_q       <= 1'b0;
      lap_cnt_q <= '0;
      laps_q    <= '0;
      rev_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      c_q       <= c_d;
      lap_cnt_q <= lap_cnt_d;
      laps_q    <= laps_d;
      rev_q     <= rev_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign Q       = q_q;
  assign C       = c_q;
  assign lap_cnt = lap_cnt_q;
  assign done    = done_q;

endmodule
